// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder producing held-key levels for space/left/right.
// Ports: clk, rst; rx_data/rx_valid in; kbd_clear in; key_* levels and proto_err out.
module ps2_key_decoder #(
  parameter logic [7:0] SPACE_CODE     = 8'h29,
  parameter logic [7:0] LEFT_CODE      = 8'h6B,
  parameter logic [7:0] RIGHT_CODE     = 8'h74,
  parameter int         TIMEOUT_CYCLES = 195_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       kbd_clear,
  output logic       key_space,
  output logic       key_left,
  output logic       key_right,
  output logic       proto_err
);

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;
  localparam int         CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    proto_err <= 1'b0;
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      key_space <= 1'b0;
      key_left  <= 1'b0;
      key_right <= 1'b0;
    end else if (kbd_clear) begin
      // a byte in the same cycle is deliberately dropped
      state     <= IDLE;
      cnt       <= '0;
      key_space <= 1'b0;
      key_left  <= 1'b0;
      key_right <= 1'b0;
    end else if (rx_valid) begin
      // every accepted byte restarts the prefix watchdog,
      // including one that lands in the expiry cycle
      cnt <= '0;
      unique case (state)
        IDLE: begin
          if (rx_data == PFX_EXT) begin
            state <= EXT;
          end else if (rx_data == PFX_BRK) begin
            state <= BRK;
          end else if (rx_data == SPACE_CODE) begin
            key_space <= 1'b1;
          end
        end
        EXT: begin
          if (rx_data == PFX_BRK) begin
            state <= EXT_BRK;
          end else if (rx_data == PFX_EXT) begin
            state <= EXT;
          end else if (rx_data == LEFT_CODE) begin
            key_left <= 1'b1;
            state    <= IDLE;
          end else if (rx_data == RIGHT_CODE) begin
            key_right <= 1'b1;
            state     <= IDLE;
          end else begin
            state <= IDLE;
          end
        end
        BRK: begin
          if (rx_data == SPACE_CODE) begin
            key_space <= 1'b0;
            state     <= IDLE;
          end else if (rx_data == PFX_BRK) begin
            state <= BRK;
          end else begin
            state <= IDLE;
          end
        end
        EXT_BRK: begin
          if (rx_data == LEFT_CODE) begin
            key_left <= 1'b0;
          end else if (rx_data == RIGHT_CODE) begin
            key_right <= 1'b0;
          end
          state <= IDLE;
        end
      endcase
    end else if (state != IDLE) begin
      // pending prefix with no byte: abandon it at the limit
      if (cnt == TLIM) begin
        state     <= IDLE;
        cnt       <= '0;
        proto_err <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: vector table plus timeout/reset sequences.
// Drives inputs #1 after posedge and samples outputs before the next edge.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       kbd_clear;
  logic       key_space;
  logic       key_left;
  logic       key_right;
  logic       proto_err;

  int n_checks = 0;
  int n_fail   = 0;

  ps2_key_decoder #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .kbd_clear(kbd_clear),
    .key_space(key_space),
    .key_left (key_left),
    .key_right(key_right),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // exp = {space, left, right, proto_err}
  typedef struct {
    string      name;
    logic       vld;
    logic       clr;
    logic [7:0] data;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [3:0] outs();
    return {key_space, key_left, key_right, proto_err};
  endfunction

  task automatic chk(input string name, input logic [3:0] exp);
    logic [3:0] act;
    act = outs();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b (space,left,right,err)",
               name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic add(input string n, input logic v, input logic c,
                     input logic [7:0] d, input logic [3:0] e);
    vec_t x;
    x.name = n;
    x.vld  = v;
    x.clr  = c;
    x.data = d;
    x.exp  = e;
    vecs.push_back(x);
  endtask

  initial begin
    add("space_make",    1, 0, 8'h29, 4'b1000);
    add("brk_pfx",       1, 0, 8'hF0, 4'b1000);
    add("space_break",   1, 0, 8'h29, 4'b0000);
    add("idle_aa",       1, 0, 8'hAA, 4'b0000);
    add("ext_pfx",       1, 0, 8'hE0, 4'b0000);
    add("left_make",     1, 0, 8'h6B, 4'b0100);
    add("ext_pfx2",      1, 0, 8'hE0, 4'b0100);
    add("right_make",    1, 0, 8'h74, 4'b0110);
    add("eb_e0",         1, 0, 8'hE0, 4'b0110);
    add("eb_f0",         1, 0, 8'hF0, 4'b0110);
    add("left_break",    1, 0, 8'h6B, 4'b0010);
    add("rb_e0",         1, 0, 8'hE0, 4'b0010);
    add("rb_f0",         1, 0, 8'hF0, 4'b0010);
    add("right_break",   1, 0, 8'h74, 4'b0000);
    add("kp4_ignored",   1, 0, 8'h6B, 4'b0000);
    add("kp6_ignored",   1, 0, 8'h74, 4'b0000);
    add("rel_e0",        1, 0, 8'hE0, 4'b0000);
    add("rel_f0",        1, 0, 8'hF0, 4'b0000);
    add("rel_rel_right", 1, 0, 8'h74, 4'b0000);
    add("rel_kp6_idle",  1, 0, 8'h74, 4'b0000);
    add("ext_other_e0",  1, 0, 8'hE0, 4'b0000);
    add("ext_other_12",  1, 0, 8'h12, 4'b0000);
    add("after_other",   1, 0, 8'h6B, 4'b0000);
    add("ee_e0",         1, 0, 8'hE0, 4'b0000);
    add("ee_e0_again",   1, 0, 8'hE0, 4'b0000);
    add("ee_left",       1, 0, 8'h6B, 4'b0100);
    for (int i = 0; i < 5; i++)
      add("typematic",   1, 0, 8'h29, 4'b1100);
    add("ff_f0",         1, 0, 8'hF0, 4'b1100);
    add("ff_f0_again",   1, 0, 8'hF0, 4'b1100);
    add("ff_space_brk",  1, 0, 8'h29, 4'b0100);
    add("sp_again",      1, 0, 8'h29, 4'b1100);
    add("r_e0",          1, 0, 8'hE0, 4'b1100);
    add("r_make",        1, 0, 8'h74, 4'b1110);
    add("clear_w_byte",  1, 1, 8'h29, 4'b0000);
    add("post_clear",    0, 0, 8'h00, 4'b0000);

    rst       = 1'b1;
    kbd_clear = 1'b0;
    rx_valid  = 1'b1;
    rx_data   = 8'h29;
    repeat (3) cyc();
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    cyc();
    chk("reset_ignores_rx", 4'b0000);

    foreach (vecs[i]) begin
      rx_valid  = vecs[i].vld;
      kbd_clear = vecs[i].clr;
      rx_data   = vecs[i].data;
      cyc();
      rx_valid  = 1'b0;
      kbd_clear = 1'b0;
      rx_data   = 8'h00;
      chk(vecs[i].name, vecs[i].exp);
    end

    // prefix timeout: E0 then silence
    send(8'hE0);
    chk("to_e0", 4'b0000);
    repeat (15) cyc();
    chk("to_before_expiry", 4'b0000);
    cyc();
    chk("to_err_pulse", 4'b0001);
    cyc();
    chk("to_err_one_cycle", 4'b0000);
    send(8'h6B);
    chk("to_then_kp4", 4'b0000);

    // byte arriving in the expiry cycle wins
    send(8'hE0);
    repeat (15) cyc();
    chk("exp_pending", 4'b0000);
    send(8'h6B);
    chk("exp_byte_wins", 4'b0100);
    cyc();
    chk("exp_no_err", 4'b0100);

    // break prefix discarded by reset
    send(8'hF0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_seq_reset", 4'b0000);
    send(8'h29);
    chk("post_reset_make", 4'b1000);

    // timeout out of BRK leaves key level unchanged
    send(8'hF0);
    repeat (16) cyc();
    chk("brk_timeout", 4'b1001);
    send(8'h29);
    chk("brk_to_then_make", 4'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
